// File: rtl/clock_pkg.sv
// Shared widths, limits and FSM encoding for the alarm-set controller.
package clock_pkg;

  localparam int MIN_W   = $clog2(60) + 1;
  localparam int HR_W    = $clog2(24) + 1;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } alarm_set_state_t;

  function automatic logic is_edit(input alarm_set_state_t st);
    return (st == EDIT_H) || (st == EDIT_M);
  endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Wrapping up/down counter over 0..MAX; a load overrides any count request.
module mod_updown_counter #(
  parameter int W   = 6,
  parameter int MAX = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W-1:0] count_s;

  // Next count: load first, then a single-direction step with wrap.
  always_comb begin
    count_s = count_r;
    if (load) begin
      count_s = load_val;
    end else if (en && up && !dn) begin
      count_s = (count_r == W'(MAX)) ? {W{1'b0}} : count_r + W'(1);
    end else if (en && dn && !up) begin
      count_s = (count_r == {W{1'b0}}) ? W'(MAX) : count_r - W'(1);
    end else begin
      count_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/alarm_setter.sv
// Button-driven alarm-set controller: edits hours then minutes, strobes set_alarm on commit.
// Optional edit timeout enabled by macro ALARM_SET_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module alarm_setter import clock_pkg::*;
`ifdef ALARM_SET_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             btn_cancel,
  output logic             set_alarm,
  output logic [MIN_W-1:0] set_minutes,
  output logic [HR_W-1:0]  set_hours,
  output logic             edit_active,
  output logic             edit_field,
  output logic             alarm_valid
);

  alarm_set_state_t state_r, state_s;
  logic             in_edit_s, timeout_s, load_s, en_h_s, en_m_s;
  logic             set_alarm_s, edit_active_s, edit_field_s;
  logic             set_alarm_r, edit_active_r, edit_field_r, alarm_valid_r;
  logic [HR_W-1:0]  hours_s, com_hours_r;
  logic [MIN_W-1:0] minutes_s, com_minutes_r;

  assign in_edit_s = is_edit(state_r);

`ifdef ALARM_SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_r;
  logic            any_btn_s;

  assign any_btn_s = btn_mode | btn_inc | btn_dec | btn_cancel;
  assign timeout_s = in_edit_s && !any_btn_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Quiet-cycle counter: runs only while editing with no button activity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (in_edit_s && !any_btn_s && !timeout_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= {TO_W{1'b0}};
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: cancel beats mode, a timeout acts like cancel.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = btn_mode ? EDIT_H : IDLE;
      EDIT_H: begin
        if (btn_cancel)     state_s = IDLE;
        else if (btn_mode)  state_s = EDIT_M;
        else if (timeout_s) state_s = IDLE;
        else                state_s = EDIT_H;
      end
      EDIT_M: begin
        if (btn_cancel)     state_s = IDLE;
        else if (btn_mode)  state_s = COMMIT;
        else if (timeout_s) state_s = IDLE;
        else                state_s = EDIT_M;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered-output values and counter controls derived from the transition.
  always_comb begin
    set_alarm_s   = (state_s == COMMIT);
    edit_active_s = is_edit(state_s);
    edit_field_s  = (state_s == EDIT_M);
    load_s = ((state_r == IDLE) && btn_mode) || (in_edit_s && (btn_cancel || timeout_s));
    en_h_s = (state_r == EDIT_H) && !btn_cancel && !btn_mode;
    en_m_s = (state_r == EDIT_M) && !btn_cancel && !btn_mode;
  end

  mod_updown_counter #(.W(HR_W), .MAX(HR_MAX)) u_hours (
    .clk(clk), .rst(rst), .en(en_h_s), .up(btn_inc), .dn(btn_dec),
    .load(load_s), .load_val(com_hours_r), .count(hours_s)
  );

  mod_updown_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_minutes (
    .clk(clk), .rst(rst), .en(en_m_s), .up(btn_inc), .dn(btn_dec),
    .load(load_s), .load_val(com_minutes_r), .count(minutes_s)
  );

  // Committed copy and validity flag, captured during the commit cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      com_hours_r   <= {HR_W{1'b0}};
      com_minutes_r <= {MIN_W{1'b0}};
      alarm_valid_r <= 1'b0;
    end else if (state_r == COMMIT) begin
      com_hours_r   <= hours_s;
      com_minutes_r <= minutes_s;
      alarm_valid_r <= 1'b1;
    end else begin
      com_hours_r   <= com_hours_r;
      com_minutes_r <= com_minutes_r;
      alarm_valid_r <= alarm_valid_r;
    end
  end

  // Output flags registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      set_alarm_r   <= 1'b0;
      edit_active_r <= 1'b0;
      edit_field_r  <= 1'b0;
    end else begin
      set_alarm_r   <= set_alarm_s;
      edit_active_r <= edit_active_s;
      edit_field_r  <= edit_field_s;
    end
  end

  assign set_alarm   = set_alarm_r;
  assign edit_active = edit_active_r;
  assign edit_field  = edit_field_r;
  assign alarm_valid = alarm_valid_r;
  assign set_hours   = hours_s;
  assign set_minutes = minutes_s;

endmodule
